// File: rtl/sobel_filter_if.sv
// Stream bundle for sobel_filter: one pixel input channel and three result channels.
// The slave modport is the filter side; master is the producer/consumer side.
interface sobel_filter_if;
  logic        i_rgb_vld;
  logic [23:0] i_rgb_data;
  logic        i_rgb_busy;

  logic        o_newR_vld;
  logic [7:0]  o_newR_data;
  logic        o_newR_busy;
  logic        o_newG_vld;
  logic [7:0]  o_newG_data;
  logic        o_newG_busy;
  logic        o_newB_vld;
  logic [7:0]  o_newB_data;
  logic        o_newB_busy;

  modport slave (
    input  i_rgb_vld, i_rgb_data,
    output i_rgb_busy,
    output o_newR_vld, o_newR_data,
    output o_newG_vld, o_newG_data,
    output o_newB_vld, o_newB_data,
    input  o_newR_busy, o_newG_busy, o_newB_busy
  );

  modport master (
    output i_rgb_vld, i_rgb_data,
    input  i_rgb_busy,
    input  o_newR_vld, o_newR_data,
    input  o_newG_vld, o_newG_data,
    input  o_newB_vld, o_newB_data,
    output o_newR_busy, o_newG_busy, o_newB_busy
  );
endinterface

// File: rtl/sobel_filter.sv
// 3x3 Sobel gradient magnitude per RGB plane: collects a raster-ordered window,
// computes |Gx|+|Gy| saturated to 8 bits, and hands each plane out on its own channel.
module sobel_filter (
  input  logic          i_clk,
  input  logic          i_rst,
  sobel_filter_if.slave bus
);

  localparam int unsigned PixW   = 24;
  localparam int unsigned ChW    = 8;
  localparam int unsigned NumPix = 9;
  localparam int unsigned CntW   = 4;
  localparam int unsigned AccW   = 12;

  typedef enum logic [1:0] {LOAD, CALC, OUT} stateT;

  stateT state, stateNext;
  logic [NumPix-1:0][PixW-1:0] window;
  logic [CntW-1:0] cnt;
  logic rgbBusy, rgbBusyNext;
  logic vldR, vldG, vldB;
  logic [ChW-1:0] dataR, dataG, dataB;
  logic inXfer, xferR, xferG, xferB, pending;
  logic [NumPix-1:0][ChW-1:0] planeR, planeG, planeB;
  logic [ChW-1:0] magR, magG, magB;

  // Saturated |Gx| + |Gy| for one colour plane
  function automatic logic [ChW-1:0] sobelMag(input logic [NumPix-1:0][ChW-1:0] p);
    logic signed [AccW-1:0] e [NumPix];
    logic signed [AccW-1:0] gx, gy;
    logic [AccW-1:0] ax, ay, mag;
    for (int i = 0; i < int'(NumPix); i++) e[i] = $signed(AccW'(p[i]));
    gx  = (e[2] - e[0]) + ((e[5] - e[3]) <<< 1) + (e[8] - e[6]);
    gy  = (e[6] - e[0]) + ((e[7] - e[1]) <<< 1) + (e[8] - e[2]);
    ax  = gx[AccW-1] ? -gx : gx;
    ay  = gy[AccW-1] ? -gy : gy;
    mag = ax + ay;
    return (mag > AccW'(255)) ? {ChW{1'b1}} : mag[ChW-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NumPix); i++) begin
      planeR[i] = window[i][7:0];
      planeG[i] = window[i][15:8];
      planeB[i] = window[i][23:16];
    end
    magR = sobelMag(planeR);
    magG = sobelMag(planeG);
    magB = sobelMag(planeB);
  end

  assign inXfer  = (state == LOAD) && bus.i_rgb_vld && !rgbBusy;
  assign xferR   = vldR && !bus.o_newR_busy;
  assign xferG   = vldG && !bus.o_newG_busy;
  assign xferB   = vldB && !bus.o_newB_busy;
  assign pending = (vldR && bus.o_newR_busy) || (vldG && bus.o_newG_busy) ||
                   (vldB && bus.o_newB_busy);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= LOAD;
      rgbBusy <= 1'b1;
    end else begin
      state   <= stateNext;
      rgbBusy <= rgbBusyNext;
    end
  end

  // Next state; input stays blocked whenever the next state is not LOAD
  always_comb begin
    stateNext = state;
    case (state)
      LOAD:    if (inXfer && cnt == CntW'(NumPix - 1)) stateNext = CALC;
      CALC:    stateNext = OUT;
      OUT:     if (!pending) stateNext = LOAD;
      default: stateNext = LOAD;
    endcase
    rgbBusyNext = (stateNext != LOAD);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      window <= '0;
      cnt    <= '0;
      vldR   <= 1'b0;
      vldG   <= 1'b0;
      vldB   <= 1'b0;
      dataR  <= '0;
      dataG  <= '0;
      dataB  <= '0;
    end else begin
      if (inXfer) begin
        for (int i = 0; i < int'(NumPix); i++)
          if (CntW'(i) == cnt) window[i] <= bus.i_rgb_data;
        cnt <= (cnt == CntW'(NumPix - 1)) ? '0 : cnt + CntW'(1);
      end
      if (state == CALC) begin
        dataR <= magR;
        dataG <= magG;
        dataB <= magB;
        vldR  <= 1'b1;
        vldG  <= 1'b1;
        vldB  <= 1'b1;
      end else begin
        if (xferR) vldR <= 1'b0;
        if (xferG) vldG <= 1'b0;
        if (xferB) vldB <= 1'b0;
      end
    end
  end

  assign bus.i_rgb_busy  = rgbBusy;
  assign bus.o_newR_vld  = vldR;
  assign bus.o_newG_vld  = vldG;
  assign bus.o_newB_vld  = vldB;
  assign bus.o_newR_data = dataR;
  assign bus.o_newG_data = dataG;
  assign bus.o_newB_data = dataB;

endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter: hand-computed windows, latency, backpressure,
// input gaps and mid-window reset.
module tb_sobel_filter;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sobel_filter_if bus();

  sobel_filter dut (
    .i_clk (clk),
    .i_rst (rstN),
    .bus   (bus.slave)
  );

  logic [8:0][23:0] winFlat, winVert, winHorz, winDiag, winJunk;

  task automatic checkVal(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendPixel(input logic [23:0] px, input int gapMax);
    int  gap;
    bit  done;
    gap  = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    done = 1'b0;
    bus.i_rgb_vld = 1'b0;
    repeat (gap) step();
    bus.i_rgb_vld  = 1'b1;
    bus.i_rgb_data = px;
    for (int t = 0; t < 40 && !done; t++) begin
      if (!bus.i_rgb_busy) done = 1'b1;
      step();
    end
    bus.i_rgb_vld = 1'b0;
    if (!done) checkVal("input_accept_timeout", 0, 1);
  endtask

  task automatic loadWindow(input logic [8:0][23:0] w, input int gapMax);
    for (int i = 0; i < 9; i++) sendPixel(w[i], gapMax);
  endtask

  task automatic waitResults(input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (bus.o_newR_vld && bus.o_newG_vld && bus.o_newB_vld) seen = 1'b1;
      else step();
    end
    if (!seen) checkVal({tag, "_result_timeout"}, 0, 1);
  endtask

  task automatic collect(input string tag, input int eR, input int eG, input int eB);
    waitResults(tag);
    checkVal({tag, "_R"}, int'(bus.o_newR_data), eR);
    checkVal({tag, "_G"}, int'(bus.o_newG_data), eG);
    checkVal({tag, "_B"}, int'(bus.o_newB_data), eB);
    checkVal({tag, "_in_busy"}, int'(bus.i_rgb_busy), 1);
    step();
    checkVal({tag, "_vld_drop"},
             int'({bus.o_newR_vld, bus.o_newG_vld, bus.o_newB_vld}), 0);
    checkVal({tag, "_in_ready"}, int'(bus.i_rgb_busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      winFlat[i] = 24'h808080;
      winVert[i] = ((i % 3) == 2) ? 24'h00FF0A : 24'h000000;
      winHorz[i] = (i >= 6) ? 24'h3F0114 : 24'h000000;
      winDiag[i] = 24'h000000;
      winJunk[i] = 24'hFFFFFF;
    end
    winDiag[0] = 24'h000064;
    winDiag[1] = 24'h003200;
    winDiag[8] = 24'h1E0000;

    rstN            = 1'b0;
    bus.i_rgb_vld   = 1'b0;
    bus.i_rgb_data  = '0;
    bus.o_newR_busy = 1'b0;
    bus.o_newG_busy = 1'b0;
    bus.o_newB_busy = 1'b0;
    repeat (3) step();

    // Reset state
    checkVal("rst_in_busy", int'(bus.i_rgb_busy), 1);
    checkVal("rst_vld", int'({bus.o_newR_vld, bus.o_newG_vld, bus.o_newB_vld}), 0);
    checkVal("rst_data", int'({bus.o_newR_data, bus.o_newG_data, bus.o_newB_data}), 0);
    rstN = 1'b1;
    #1;
    checkVal("rst_release_busy", int'(bus.i_rgb_busy), 1);
    step();
    checkVal("rst_first_edge_ready", int'(bus.i_rgb_busy), 0);

    // Uniform window with exact latency: p8 at edge N, vld after N+1, ready after N+2
    loadWindow(winFlat, 0);
    checkVal("flat_N_vld", int'({bus.o_newR_vld, bus.o_newG_vld, bus.o_newB_vld}), 0);
    checkVal("flat_N_busy", int'(bus.i_rgb_busy), 1);
    step();
    checkVal("flat_N1_vld", int'({bus.o_newR_vld, bus.o_newG_vld, bus.o_newB_vld}), 7);
    checkVal("flat_N1_data", int'({bus.o_newR_data, bus.o_newG_data, bus.o_newB_data}), 0);
    checkVal("flat_N1_busy", int'(bus.i_rgb_busy), 1);
    step();
    checkVal("flat_N2_vld", int'({bus.o_newR_vld, bus.o_newG_vld, bus.o_newB_vld}), 0);
    checkVal("flat_N2_busy", int'(bus.i_rgb_busy), 0);

    // Vertical and horizontal edges, then a sign/abs test on single pixels
    loadWindow(winVert, 0);
    collect("vert", 40, 255, 0);
    loadWindow(winHorz, 0);
    collect("horz", 80, 4, 252);
    loadWindow(winDiag, 0);
    collect("diag", 200, 100, 60);

    // G channel held off for 5 cycles while R and B drain
    bus.o_newG_busy = 1'b1;
    loadWindow(winHorz, 0);
    step();
    checkVal("bp_N1_vld", int'({bus.o_newR_vld, bus.o_newG_vld, bus.o_newB_vld}), 7);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) checkVal("bp_RB_gone", int'({bus.o_newR_vld, bus.o_newB_vld}), 0);
      checkVal($sformatf("bp_G_vld_%0d", k), int'(bus.o_newG_vld), 1);
      checkVal($sformatf("bp_G_data_%0d", k), int'(bus.o_newG_data), 4);
      checkVal($sformatf("bp_in_busy_%0d", k), int'(bus.i_rgb_busy), 1);
    end
    bus.o_newG_busy = 1'b0;
    step();
    checkVal("bp_G_done", int'(bus.o_newG_vld), 0);
    checkVal("bp_in_ready", int'(bus.i_rgb_busy), 0);

    // Random input gaps
    loadWindow(winDiag, 3);
    collect("gaps_diag", 200, 100, 60);
    loadWindow(winVert, 4);
    collect("gaps_vert", 40, 255, 0);

    // Reset after 4 pixels discards the partial window
    for (int i = 0; i < 4; i++) sendPixel(winJunk[i], 0);
    rstN = 1'b0;
    #1;
    checkVal("midload_rst_busy", int'(bus.i_rgb_busy), 1);
    step();
    rstN = 1'b1;
    step();
    loadWindow(winVert, 0);
    collect("after_rst", 40, 255, 0);

    // Reset while results are pending discards them
    bus.o_newR_busy = 1'b1;
    loadWindow(winJunk, 0);
    waitResults("midout");
    rstN = 1'b0;
    #1;
    checkVal("midout_rst_vld", int'({bus.o_newR_vld, bus.o_newG_vld, bus.o_newB_vld}), 0);
    checkVal("midout_rst_data", int'({bus.o_newR_data, bus.o_newG_data, bus.o_newB_data}), 0);
    bus.o_newR_busy = 1'b0;
    step();
    rstN = 1'b1;
    step();
    loadWindow(winHorz, 0);
    collect("after_rst2", 80, 4, 252);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
